// File: rtl/pla_eval_pkg.sv
// -----------------------------------------------------------------------------
// pla_eval_pkg
// Shared widths and the response-entry layout for the PLA evaluation scheduler.
//   PLA_IN_W  : PLA input vector width  (x0..x6)
//   PLA_OUT_W : PLA output vector width (z0..z9)
//   MAX_ID_W  : widest requester tag carried in a response entry; users
//               truncate it to their own ID_W.
// -----------------------------------------------------------------------------
package pla_eval_pkg;

  localparam int PLA_IN_W  = 7;
  localparam int PLA_OUT_W = 10;
  localparam int MAX_ID_W  = 3;

  typedef struct packed {
    logic [PLA_OUT_W-1:0] z;
    logic [PLA_IN_W-1:0]  x;
    logic [MAX_ID_W-1:0]  id;
  } pla_rsp_t;

endpackage

// File: rtl/pla_eval_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with an owned rotating priority pointer. The search
// starts at the pointer and wraps modulo NUM_REQ; after a grant the pointer
// moves to one past the winner, otherwise it holds.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointer -> 0)
//   i_req       : per-requester request
//   i_en        : grant enable (no grant when low)
//   o_gnt       : one-hot grant (or zero), combinational
//   o_gnt_idx   : index of the granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;
  logic [IDX_W-1:0] w_j;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_j       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_j = IDX_W'((int'(r_ptr) + i) % NUM_REQ);
      if (i_en && !w_found && i_req[w_j]) begin
        w_found      = 1'b1;
        o_gnt[w_j]   = 1'b1;
        o_gnt_idx    = w_j;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (|o_gnt) begin
      r_ptr <= (o_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/pla_eval_sched.sv
// -----------------------------------------------------------------------------
// pla_eval_sched
// Time-shares one external combinational PLA (x0..x6 -> z0..z9) among NUM_REQ
// requesters. A round-robin arbiter issues at most one vector per cycle into a
// registered stage driving pla_x; the PLA result is captured on the next edge
// into a response FIFO together with the vector and the requester id.
// Issue is credit-gated so the FIFO can never overflow: a slot must exist for
// every vector already in flight (fifo count + stage-1 valid < RSP_DEPTH).
// A pop does not return credit until the following cycle.
//
// Optional build macro: PLA_EVAL_SCHED_CHECK_EN
//   Defined  : each captured PLA result is checked against the identities
//              z8 == ~x3, z7 == x2^x3, z6 == ~x1 ^ (x2|~x3); a mismatch sets
//              the sticky chk_err. Data is pushed unchanged.
//   Undefined: chk_err is tied low.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : per-requester request valid
//   req_ready   : per-requester accept, one-hot or zero (combinational)
//   req_x       : per-requester vectors, slice i = [7*i+6:7*i]
//   pla_x       : registered vector to the PLA inputs (holds when idle)
//   pla_z       : PLA outputs, combinational from pla_x
//   rsp_valid / rsp_ready : response handshake
//   rsp_z, rsp_x, rsp_id  : head FIFO entry
//   eval_cnt    : saturating count of captured evaluations
//   chk_err     : sticky PLA self-check error
// -----------------------------------------------------------------------------
module pla_eval_sched
  import pla_eval_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int RSP_DEPTH = 2,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*PLA_IN_W-1:0] req_x,
  output logic [PLA_IN_W-1:0]         pla_x,
  input  logic [PLA_OUT_W-1:0]        pla_z,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [PLA_OUT_W-1:0]        rsp_z,
  output logic [PLA_IN_W-1:0]         rsp_x,
  output logic [ID_W-1:0]             rsp_id,
  output logic [15:0]                 eval_cnt,
  output logic                        chk_err
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_gnt_idx;
  logic                w_credit;
  logic [CNT_W:0]      w_occ;
  logic [PLA_IN_W-1:0] w_sel_x;

  logic                r_s1_valid;
  logic [PLA_IN_W-1:0] r_s1_x;
  logic [ID_W-1:0]     r_s1_id;

  pla_rsp_t            r_mem [RSP_DEPTH];
  logic [PTR_W-1:0]    r_wr;
  logic [PTR_W-1:0]    r_rd;
  logic [CNT_W-1:0]    r_cnt;
  logic [15:0]         r_eval_cnt;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  pla_rsp_t            w_push_data;
  pla_rsp_t            w_head;
  logic                w_unused_id;

  // Credit counts the in-flight stage-1 entry; same-cycle pops are ignored.
  always_comb begin
    w_occ    = {1'b0, r_cnt} + {{CNT_W{1'b0}}, r_s1_valid};
    w_credit = (w_occ < (CNT_W + 1)'(RSP_DEPTH));
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (req_valid),
    .i_en      (w_credit),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign req_ready = w_gnt;

  always_comb begin
    w_sel_x = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_sel_x = req_x[i*PLA_IN_W +: PLA_IN_W];
    end
  end

  // Stage 1: issue register driving the PLA inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_id    <= '0;
    end else begin
      r_s1_valid <= |w_gnt;
      if (|w_gnt) begin
        r_s1_x  <= w_sel_x;
        r_s1_id <= w_gnt_idx;
      end
    end
  end

  assign pla_x = r_s1_x;

  // Stage 2: capture PLA result into the response FIFO
  always_comb begin
    w_push_data    = '0;
    w_push_data.z  = pla_z;
    w_push_data.x  = r_s1_x;
    w_push_data.id = MAX_ID_W'(r_s1_id);
  end

  assign w_push = r_s1_valid;
  assign w_pop  = rsp_valid && rsp_ready;
  assign w_full = (r_cnt == CNT_W'(RSP_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) r_mem[i] <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_eval_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_push_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_push && (r_eval_cnt != 16'hFFFF)) r_eval_cnt <= r_eval_cnt + 16'd1;
    end
  end

  assign w_head      = r_mem[r_rd];
  assign rsp_valid   = (r_cnt != '0);
  assign rsp_z       = w_head.z;
  assign rsp_x       = w_head.x;
  assign rsp_id      = w_head.id[ID_W-1:0];
  assign eval_cnt    = r_eval_cnt;
  // Upper tag bits beyond ID_W are always zero here.
  assign w_unused_id = ^w_head.id;

`ifdef PLA_EVAL_SCHED_CHECK_EN
  logic w_chk_bad;
  logic r_chk_err;

  always_comb begin
    w_chk_bad = (pla_z[8] != ~r_s1_x[3]) ||
                (pla_z[7] != (r_s1_x[2] ^ r_s1_x[3])) ||
                (pla_z[6] != (~r_s1_x[1] ^ (r_s1_x[2] | ~r_s1_x[3])));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_err <= 1'b0;
    end else if (w_push && w_chk_bad) begin
      r_chk_err <= 1'b1;
    end
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

`ifndef SYNTHESIS
  // Credit gating makes a push into a full FIFO a design bug.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(w_push && w_full && !w_pop))
        else $error("pla_eval_sched: push into full response FIFO");
    end
  end
`endif

endmodule

// File: tb/tb_pla_eval_sched.sv
module tb_pla_eval_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [27:0] req_x;
  logic [6:0]  pla_x;
  logic [9:0]  pla_z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [9:0]  rsp_z;
  logic [6:0]  rsp_x;
  logic [1:0]  rsp_id;
  logic [15:0] eval_cnt;
  logic        chk_err;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PLA_EVAL_SCHED_CHECK_EN
  localparam logic EXP_CHK = 1'b1;
`else
  localparam logic EXP_CHK = 1'b0;
`endif

  localparam logic [27:0] FAIR_X = {7'h4C, 7'h33, 7'h2A, 7'h15};

  pla_eval_sched #(.NUM_REQ(4), .RSP_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .pla_x     (pla_x),
    .pla_z     (pla_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_x     (rsp_x),
    .rsp_id    (rsp_id),
    .eval_cnt  (eval_cnt),
    .chk_err   (chk_err)
  );

  always #5 clk = ~clk;

  // Bench PLA: satisfies the checked identities; z8 is corrupted for x=0
  // only when the self-check build is enabled.
  function automatic logic [9:0] pla_model(input logic [6:0] x);
    logic [9:0] z;
    z[9]   = x[0] & x[6];
    z[8]   = ~x[3];
    z[7]   = x[2] ^ x[3];
    z[6]   = ~x[1] ^ (x[2] | ~x[3]);
    z[5:0] = x[5:0] ^ 6'b101101 ^ {6{x[6]}};
`ifdef PLA_EVAL_SCHED_CHECK_EN
    if (x == 7'h00) z[8] = ~z[8];
`endif
    return z;
  endfunction

  always_comb pla_z = pla_model(pla_x);

  function automatic logic [6:0] slice_x(input logic [27:0] v, input int i);
    return v[i*7 +: 7];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_x = '0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (pla_x !== 7'h00) begin n_fail++; $display("FAIL reset_pla_x: got %h want 00", pla_x); end
    n_checks++; if (eval_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_eval_cnt: got %h want 0000", eval_cnt); end
    n_checks++; if (chk_err !== 1'b0) begin n_fail++; $display("FAIL reset_chk_err: got %b want 0", chk_err); end
    n_checks++; if ({rsp_z, rsp_x, rsp_id} !== 19'h0) begin n_fail++; $display("FAIL reset_rsp_fields: got %h want 0", {rsp_z, rsp_x, rsp_id}); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    req_x = {21'h0, 7'b0001000}; req_valid = 4'b0001; rsp_ready = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_req_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", rsp_valid); end
    n_checks++; if (pla_x !== 7'b0001000) begin n_fail++; $display("FAIL single_pla_x: got %b want 0001000", pla_x); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_rsp_id: got %0d want 0", rsp_id); end
    n_checks++; if (rsp_x !== 7'b0001000) begin n_fail++; $display("FAIL single_rsp_x: got %b want 0001000", rsp_x); end
    n_checks++; if (rsp_z[8:6] !== 3'b011) begin n_fail++; $display("FAIL single_rsp_z86: got %b want 011", rsp_z[8:6]); end
    n_checks++; if (rsp_z !== pla_model(7'b0001000)) begin n_fail++; $display("FAIL single_rsp_z: got %h want %h", rsp_z, pla_model(7'b0001000)); end
    n_checks++; if (eval_cnt !== 16'd1) begin n_fail++; $display("FAIL single_eval_cnt: got %0d want 1", eval_cnt); end
    n_checks++; if (chk_err !== 1'b0) begin n_fail++; $display("FAIL single_chk_err: got %b want 0", chk_err); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_after_pop: got %b want 0", rsp_valid); end
    n_checks++; if (pla_x !== 7'b0001000) begin n_fail++; $display("FAIL single_pla_hold: got %b want 0001000", pla_x); end
  endtask

  task automatic test_fairness();
    int grants[$];
    int ids[$];
    logic [6:0] xs[$];
    logic [9:0] zs[$];
    logic onehot_ok;
    onehot_ok = 1'b1;
    do_reset();
    req_x = FAIR_X; req_valid = 4'hF; rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 80 && ids.size() < 8; c++) begin
      if (req_ready != 4'b0000) begin
        if ($countones(req_ready) != 1) onehot_ok = 1'b0;
        for (int k = 0; k < 4; k++) if (req_ready[k]) grants.push_back(k);
      end
      if (rsp_valid) begin
        ids.push_back(int'(rsp_id)); xs.push_back(rsp_x); zs.push_back(rsp_z);
      end
      tick();
      if (grants.size() >= 8) req_valid = 4'h0;
      #1;
    end
    n_checks++; if (ids.size() != 8) begin n_fail++; $display("FAIL fair_rsp_count: got %0d want 8", ids.size()); end
    n_checks++; if (grants.size() != 8) begin n_fail++; $display("FAIL fair_grant_count: got %0d want 8", grants.size()); end
    n_checks++; if (onehot_ok !== 1'b1) begin n_fail++; $display("FAIL fair_onehot: got %b want 1", onehot_ok); end
    for (int k = 0; k < grants.size(); k++) begin
      n_checks++; if (grants[k] != k % 4) begin n_fail++; $display("FAIL fair_grant[%0d]: got %0d want %0d", k, grants[k], k % 4); end
    end
    for (int k = 0; k < ids.size(); k++) begin
      n_checks++; if (ids[k] != k % 4) begin n_fail++; $display("FAIL fair_id[%0d]: got %0d want %0d", k, ids[k], k % 4); end
      n_checks++; if (xs[k] !== slice_x(FAIR_X, k % 4)) begin n_fail++; $display("FAIL fair_x[%0d]: got %h want %h", k, xs[k], slice_x(FAIR_X, k % 4)); end
      n_checks++; if (zs[k] !== pla_model(slice_x(FAIR_X, k % 4))) begin n_fail++; $display("FAIL fair_z[%0d]: got %h want %h", k, zs[k], pla_model(slice_x(FAIR_X, k % 4))); end
    end
    n_checks++; if (eval_cnt !== 16'd8) begin n_fail++; $display("FAIL fair_eval_cnt: got %0d want 8", eval_cnt); end
  endtask

  task automatic test_backpressure();
    int ng;
    int first_g;
    int gid;
    int ids[$];
    ng = 0; first_g = -1; gid = -1;
    do_reset();
    req_x = FAIR_X; req_valid = 4'hF; rsp_ready = 1'b0;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (req_ready != 4'b0000) ng++;
      tick();
    end
    n_checks++; if (ng != 2) begin n_fail++; $display("FAIL bp_grants: got %0d want 2", ng); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stalled: got %b want 0000", req_ready); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL bp_head_id: got %0d want 0", rsp_id); end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_no_same_cycle_credit: got %b want 0000", req_ready); end
    for (int c = 0; c < 20 && ids.size() < 3; c++) begin
      if (rsp_valid) ids.push_back(int'(rsp_id));
      if (req_ready != 4'b0000 && first_g < 0) begin
        first_g = c;
        for (int k = 0; k < 4; k++) if (req_ready[k]) gid = k;
      end
      tick();
      if (first_g >= 0) req_valid = 4'h0;
      #1;
    end
    n_checks++; if (first_g != 1) begin n_fail++; $display("FAIL bp_first_grant_cycle: got %0d want 1", first_g); end
    n_checks++; if (gid != 2) begin n_fail++; $display("FAIL bp_grant_id: got %0d want 2", gid); end
    n_checks++; if (ids.size() != 3) begin n_fail++; $display("FAIL bp_rsp_count: got %0d want 3", ids.size()); end
    for (int k = 0; k < ids.size(); k++) begin
      n_checks++; if (ids[k] != k) begin n_fail++; $display("FAIL bp_id[%0d]: got %0d want %0d", k, ids[k], k); end
    end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", rsp_valid); end
    n_checks++; if (eval_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_eval_cnt: got %0d want 3", eval_cnt); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_x = FAIR_X; req_valid = 4'hF; rsp_ready = 1'b0;
    #1;
    tick();
    tick();
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b want 1", rsp_valid); end
    n_checks++; if (eval_cnt !== 16'd1) begin n_fail++; $display("FAIL rmid_pre_cnt: got %0d want 1", eval_cnt); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (eval_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_eval_cnt: got %0d want 0", eval_cnt); end
    n_checks++; if (pla_x !== 7'h00) begin n_fail++; $display("FAIL rmid_pla_x: got %h want 00", pla_x); end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_first_grant: got %b want 0001", req_ready); end
    tick();
    n_checks++; if (pla_x !== slice_x(FAIR_X, 0)) begin n_fail++; $display("FAIL rmid_pla_x_after: got %h want %h", pla_x, slice_x(FAIR_X, 0)); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_fifo_cleared: got %b want 0", rsp_valid); end
    req_valid = 4'h0;
  endtask

  task automatic test_chk();
    do_reset();
    req_x = '0; req_valid = 4'b0001; rsp_ready = 1'b0;
    #1;
    tick();
    req_valid = 4'h0;
    #1;
    n_checks++; if (chk_err !== 1'b0) begin n_fail++; $display("FAIL chk_before_capture: got %b want 0", chk_err); end
    tick();
    n_checks++; if (chk_err !== EXP_CHK) begin n_fail++; $display("FAIL chk_rise: got %b want %b", chk_err, EXP_CHK); end
    n_checks++; if (rsp_z !== pla_model(7'h00)) begin n_fail++; $display("FAIL chk_data: got %h want %h", rsp_z, pla_model(7'h00)); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    repeat (3) tick();
    n_checks++; if (chk_err !== EXP_CHK) begin n_fail++; $display("FAIL chk_sticky: got %b want %b", chk_err, EXP_CHK); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout want completion");
    $fatal(1, "tb_pla_eval_sched timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_chk();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
